// File: rtl/dataflow_stream_source.sv
// dataflow_stream_source: emits a programmable arithmetic sequence of signed tokens
// on a valid/ready port, with optional idle cycles between accepted tokens.
`default_nettype none

module dataflow_stream_source #(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int GAP_WIDTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] stride,
  input  logic [COUNT_WIDTH-1:0]  count,
  input  logic [GAP_WIDTH-1:0]    gap,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic [COUNT_WIDTH-1:0]  sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0] stride_q;
  logic [COUNT_WIDTH-1:0]  count_q;
  logic [GAP_WIDTH-1:0]    gap_q;
  logic [GAP_WIDTH-1:0]    gap_cnt;

  logic                   fire;
  logic [COUNT_WIDTH-1:0] sent_inc;
  logic                   last_fire;

  assign fire      = (state == S_SEND) && out_ready;
  assign sent_inc  = sent + COUNT_WIDTH'(1);
  assign last_fire = (sent_inc == count_q);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = (count == '0) ? S_DONE : S_SEND;
      end
      S_SEND: begin
        if (fire) begin
          if (last_fire)        state_next = S_DONE;
          else if (gap_q != '0) state_next = S_GAP;
          else                  state_next = S_SEND;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_WIDTH'(1)) state_next = S_SEND;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= (state_next == S_SEND);
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data <= '0;
      stride_q <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
      sent     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            out_data <= base;
            stride_q <= stride;
            count_q  <= count;
            gap_q    <= gap;
            sent     <= '0;
          end
        end
        S_SEND: begin
          if (fire) begin
            sent    <= sent_inc;
            gap_cnt <= gap_q;
            // The last token stays on out_data; only intermediate tokens advance.
            if (!last_fire) out_data <= out_data + stride_q;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - GAP_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
